// File: rtl/axi2mem_tcdm_responder.sv
// TCDM responder: NB_PORTS request channels share one single-port word SRAM
// through a round-robin arbiter. One grant per cycle, response one cycle later.
module axi2mem_tcdm_responder #(
  parameter int NB_PORTS  = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic [NB_PORTS-1:0]       tcdm_req_i,
  input  logic [NB_PORTS-1:0][31:0] tcdm_add_i,
  input  logic [NB_PORTS-1:0]       tcdm_we_i,
  input  logic [NB_PORTS-1:0][31:0] tcdm_wdata_i,
  input  logic [NB_PORTS-1:0][3:0]  tcdm_be_i,
  output logic [NB_PORTS-1:0]       tcdm_gnt_o,
  output logic [NB_PORTS-1:0][31:0] tcdm_r_rdata_o,
  output logic [NB_PORTS-1:0]       tcdm_r_valid_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(NB_PORTS);

  logic [PW-1:0]       rr_q;
  logic [PW-1:0]       rr_d;
  logic [PW-1:0]       win;
  logic [PW:0]         cand;
  logic                found;
  logic [NB_PORTS-1:0] gnt;
  logic [NB_PORTS-1:0] r_valid_q;
  logic [31:0]         r_rdata_q;

  logic [31:0]         sel_add;
  logic                sel_we;
  logic [31:0]         sel_wdata;
  logic [3:0]          sel_be;
  logic [AW-1:0]       idx;
  logic                unused_add_bits;

  logic [31:0]         mem [MEM_WORDS];

  // Round-robin scan starting at rr_q; reset and stall suppress every grant.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    if (!rst_i && !stall_i) begin
      for (int k = 0; k < NB_PORTS; k++) begin
        cand = {1'b0, rr_q} + (PW+1)'(k);
        if (cand >= (PW+1)'(NB_PORTS)) begin
          cand = cand - (PW+1)'(NB_PORTS);
        end
        if (!found && tcdm_req_i[cand[PW-1:0]]) begin
          found = 1'b1;
          win   = cand[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found) begin
      gnt[win] = 1'b1;
    end
  end

  assign rr_d = (win == PW'(NB_PORTS - 1)) ? '0 : win + PW'(1);

  assign sel_add   = tcdm_add_i[win];
  assign sel_we    = tcdm_we_i[win];
  assign sel_wdata = tcdm_wdata_i[win];
  assign sel_be    = tcdm_be_i[win];

  // Only the word index is decoded; byte offset and upper bits alias.
  assign idx             = sel_add[AW+1:2];
  assign unused_add_bits = ^{sel_add[31:AW+2], sel_add[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      r_valid_q <= '0;
      r_rdata_q <= '0;
    end else begin
      r_valid_q <= gnt;
      if (found) begin
        rr_q      <= rr_d;
        r_rdata_q <= sel_we ? 32'h0 : mem[idx];
      end
    end
  end

  // SRAM array is not reset; byte lanes commit at the grant edge.
  always_ff @(posedge clk_i) begin
    if (found && sel_we) begin
      for (int k = 0; k < 4; k++) begin
        if (sel_be[k]) begin
          mem[idx][8*k +: 8] <= sel_wdata[8*k +: 8];
        end
      end
    end
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = rst_i ? '0 : r_valid_q;
  assign tcdm_r_rdata_o = {NB_PORTS{r_rdata_q}};

endmodule
